// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: turns the asynchronous PLL lock flag into a clean,
// synchronous system reset and tracks loss-of-lock events while running.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD    = 16,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 locked,
  input  logic                 clear_count,
  output logic                 sys_reset,
  output logic                 ready,
  output logic                 lock_lost,
  output logic [CNT_WIDTH-1:0] lost_count,
  output logic [1:0]           state
);

  // Shared stabilise/hold counter is sized for the longer of the two intervals.
  localparam int unsigned MAX_CYCLES = (STABLE_CYCLES > RESET_HOLD) ? STABLE_CYCLES : RESET_HOLD;
  localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [1:0] ST_WAIT_LOCK  = 2'd0;
  localparam logic [1:0] ST_STABILIZE  = 2'd1;
  localparam logic [1:0] ST_HOLD_RESET = 2'd2;
  localparam logic [1:0] ST_RUN        = 2'd3;

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_nxt_c;
  logic [1:0]             state_nxt_c;
  logic                   loss_c;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser for the asynchronous lock flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  // Next-state and counter logic; any low on lock_s before RUN restarts acquisition.
  always_comb begin
    state_nxt_c = state;
    cnt_nxt_c   = cnt_q;
    loss_c      = 1'b0;
    case (state)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt_c = ST_STABILIZE;
          cnt_nxt_c   = '0;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          state_nxt_c = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_nxt_c = ST_HOLD_RESET;
          cnt_nxt_c   = '0;
        end else begin
          cnt_nxt_c = cnt_q + CW'(1);
        end
      end
      ST_HOLD_RESET: begin
        if (!lock_s) begin
          state_nxt_c = ST_WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_nxt_c = ST_RUN;
        end else begin
          cnt_nxt_c = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt_c = ST_WAIT_LOCK;
          loss_c      = 1'b1;
        end
      end
      default: begin
        state_nxt_c = ST_WAIT_LOCK;
      end
    endcase
  end

  // State register with outputs decoded from the next state so they move together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt_c;
      cnt_q     <= cnt_nxt_c;
      sys_reset <= (state_nxt_c != ST_RUN);
      ready     <= (state_nxt_c == ST_RUN);
    end
  end

  // Loss-of-lock bookkeeping; a loss on the same edge as a clear wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      lost_count <= '0;
      lock_lost  <= 1'b0;
    end else if (loss_c) begin
      lock_lost <= 1'b1;
      if (clear_count) begin
        lost_count <= CNT_WIDTH'(1);
      end else if (!(&lost_count)) begin
        lost_count <= lost_count + CNT_WIDTH'(1);
      end
    end else if (clear_count) begin
      lost_count <= '0;
      lock_lost  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer (SYNC=2, STABLE=8, HOLD=4, CNT=2).
module tb_pll_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       locked;
  logic       clear_count;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [1:0] lost_count;
  logic [1:0] state;

  int checks;
  int errors;

  pll_reset_sequencer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .RESET_HOLD   (4),
    .CNT_WIDTH    (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .locked     (locked),
    .clear_count(clear_count),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .lost_count (lost_count),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hand-derived acquisition profile: edges 1-2 sync, 3-10 stabilise, 11-14 hold, 15 run.
  function automatic logic [1:0] acq_state(input int e);
    if (e <= 2)       return 2'd0;
    else if (e <= 10) return 2'd1;
    else if (e <= 14) return 2'd2;
    else              return 2'd3;
  endfunction

  // Holds locked high for 15 edges and checks state/sys_reset/ready at each edge.
  task automatic test_acquire(input string tag);
    locked = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      checks++;
      if (state !== acq_state(e)) begin
        errors++;
        $display("FAIL %s_state edge %0d: got %0d expected %0d", tag, e, state, acq_state(e));
      end
      checks++;
      if (sys_reset !== (e < 15) || ready !== (e >= 15)) begin
        errors++;
        $display("FAIL %s_sysrst edge %0d: got sys_reset=%0b ready=%0b expected %0b/%0b",
                 tag, e, sys_reset, ready, (e < 15), (e >= 15));
      end
    end
  endtask

  // Drops lock from RUN for 3 edges (enough for the loss to register), then relocks.
  task automatic lose_and_relock();
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    repeat (15) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; locked = 1'b0; clear_count = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    checks++;
    if (sys_reset !== 1'b1 || ready !== 1'b0 || state !== 2'd0 ||
        lost_count !== 2'd0 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got sys_reset=%0b ready=%0b state=%0d count=%0d lost=%0b expected 1 0 0 0 0",
               sys_reset, ready, state, lost_count, lock_lost);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (sys_reset !== 1'b1 || ready !== 1'b0 || state !== 2'd0 || lost_count !== 2'd0) begin
        errors++;
        $display("FAIL idle_unlocked cycle %0d: got sys_reset=%0b ready=%0b state=%0d count=%0d expected 1 0 0 0",
                 i, sys_reset, ready, state, lost_count);
      end
    end
  endtask

  task automatic test_glitch();
    locked = 1'b1;
    repeat (5) tick();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL glitch_pre_state: got %0d expected 1", state);
    end
    locked = 1'b0;
    repeat (3) tick();
    checks++;
    if (state !== 2'd0 || lost_count !== 2'd0 || lock_lost !== 1'b0 || sys_reset !== 1'b1) begin
      errors++;
      $display("FAIL glitch_abort: got state=%0d count=%0d lost=%0b sys_reset=%0b expected 0 0 0 1",
               state, lost_count, lock_lost, sys_reset);
    end
    test_acquire("reacquire");
  endtask

  task automatic test_loss();
    locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (e < 3) begin
        if (sys_reset !== 1'b0 || state !== 2'd3 || lost_count !== 2'd0) begin
          errors++;
          $display("FAIL loss_early edge %0d: got sys_reset=%0b state=%0d count=%0d expected 0 3 0",
                   e, sys_reset, state, lost_count);
        end
      end else begin
        if (sys_reset !== 1'b1 || ready !== 1'b0 || state !== 2'd0 ||
            lost_count !== 2'd1 || lock_lost !== 1'b1) begin
          errors++;
          $display("FAIL loss_edge3: got sys_reset=%0b ready=%0b state=%0d count=%0d lost=%0b expected 1 0 0 1 1",
                   sys_reset, ready, state, lost_count, lock_lost);
        end
      end
    end
    repeat (2) tick();
    test_acquire("relock");
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd2; exp_cnt[1] = 2'd3; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    checks++;
    if (lost_count !== 2'd0 || lock_lost !== 1'b0 || state !== 2'd3) begin
      errors++;
      $display("FAIL clear_in_run: got count=%0d lost=%0b state=%0d expected 0 0 3", lost_count, lock_lost, state);
    end
    // First loss after clear reads 1; the remaining four continue 2,3,3,3.
    lose_and_relock();
    checks++;
    if (lost_count !== 2'd1 || lock_lost !== 1'b1 || state !== 2'd3) begin
      errors++;
      $display("FAIL sat_loss0: got count=%0d lost=%0b state=%0d expected 1 1 3", lost_count, lock_lost, state);
    end
    for (int k = 0; k < 4; k++) begin
      lose_and_relock();
      checks++;
      if (lost_count !== exp_cnt[k] || state !== 2'd3) begin
        errors++;
        $display("FAIL sat_loss%0d: got count=%0d state=%0d expected %0d 3", k + 1, lost_count, state, exp_cnt[k]);
      end
    end
    // Clear coincident with the loss edge: loss wins, count restarts at 1.
    locked = 1'b0;
    repeat (2) tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    checks++;
    if (lost_count !== 2'd1 || lock_lost !== 1'b1 || state !== 2'd0) begin
      errors++;
      $display("FAIL clear_vs_loss: got count=%0d lost=%0b state=%0d expected 1 1 0", lost_count, lock_lost, state);
    end
    locked = 1'b1;
    repeat (15) tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    checks++;
    if (lost_count !== 2'd0 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL clear_pulse: got count=%0d lost=%0b expected 0 0", lost_count, lock_lost);
    end
  endtask

  task automatic test_reset_mid_run();
    lose_and_relock();
    lose_and_relock();
    checks++;
    if (lost_count !== 2'd2 || state !== 2'd3) begin
      errors++;
      $display("FAIL pre_reset: got count=%0d state=%0d expected 2 3", lost_count, state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (state !== 2'd0 || sys_reset !== 1'b1 || ready !== 1'b0 ||
        lost_count !== 2'd0 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got state=%0d sys_reset=%0b ready=%0b count=%0d lost=%0b expected 0 1 0 0 0",
               state, sys_reset, ready, lost_count, lock_lost);
    end
    test_acquire("post_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    locked = 1'b0;
    clear_count = 1'b0;
    test_reset();
    test_acquire("acquire");
    test_loss();
    // Return to a fresh WAIT_LOCK for the glitch scenario.
    reset = 1'b1;
    locked = 1'b0;
    tick();
    reset = 1'b0;
    test_glitch();
    test_saturate();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumer end of the SB_PLL40_CORE clock path: runs on the PLL's 40 MHz output and turns its asynchronous `locked` flag into a clean, synchronous system reset for the ADC capture logic. It synchronises `locked`, requires it to be stable for a programmable time, and holds reset for a further programmable time before releasing. It then watches for loss of lock during operation, re-asserting reset and counting each event.

## Interface

Parameters:
- SYNC_STAGES, 2, synchroniser depth for `locked` (legal range ≥2)
- STABLE_CYCLES, 1024, consecutive synchronised-high cycles of `locked` required (≥1)
- RESET_HOLD, 16, extra cycles `sys_reset` stays high after stability is reached (≥1)
- CNT_WIDTH, 8, width of the loss-of-lock counter

Ports:
- clock  in  1  PLL output clock (40 MHz); the only clock
- reset  in  1  synchronous, active-high
- locked  in  1  PLL lock flag, asynchronous to `clock`
- clear_count  in  1  synchronous pulse; clears `lost_count` and `lock_lost`
- sys_reset  out  1  registered system reset, active-high
- ready  out  1  registered; high only in RUN
- lock_lost  out  1  sticky flag, set on any loss of lock from RUN
- lost_count  out  CNT_WIDTH  saturating count of losses of lock from RUN
- state  out  2  debug: WAIT_LOCK=0, STABILIZE=1, HOLD_RESET=2, RUN=3

## Operation

- `locked` passes through a SYNC_STAGES flop chain. `lock_s` is the last stage. The FSM uses only `lock_s`.
- One internal counter is shared by STABILIZE and HOLD_RESET. Its width is clog2 of max(STABLE_CYCLES, RESET_HOLD), minimum 1 bit.
- WAIT_LOCK: `sys_reset`=1, `ready`=0. If `lock_s`=1, go to STABILIZE and clear the counter.
- STABILIZE: `sys_reset`=1.
  - `lock_s`=0: go to WAIT_LOCK. This event is not counted.
  - Counter == STABLE_CYCLES-1: go to HOLD_RESET and clear the counter.
  - Otherwise: increment the counter.
- HOLD_RESET: `sys_reset`=1.
  - `lock_s`=0: go to WAIT_LOCK. This event is not counted.
  - Counter == RESET_HOLD-1: go to RUN.
  - Otherwise: increment the counter.
- RUN: `sys_reset`=0, `ready`=1. If `lock_s`=0, go to WAIT_LOCK, increment `lost_count` (saturating at 2^CNT_WIDTH-1), and set `lock_lost`.
- Outputs are registered and decoded from the next state, so `sys_reset`, `ready` and `state` change on the same edge as the transition.
- `clear_count`: zeroes `lost_count` and `lock_lost` on the next edge. If it coincides with a loss event, the loss wins: `lost_count`=1, `lock_lost`=1.
- `reset` has priority over everything. Applied mid-operation, on the next edge it forces:
  - state WAIT_LOCK, `sys_reset`=1, `ready`=0
  - counter, synchroniser, `lost_count` and `lock_lost` all cleared.

## Timing

- Reset values: `sys_reset`=1, `ready`=0, `lock_lost`=0, `lost_count`=0, `state`=0, synchroniser all 0.
- Acquisition latency: count edge 1 as the first edge sampling `locked`=1, with `locked` held high. `sys_reset` falls and `ready` rises after edge SYNC_STAGES+1+STABLE_CYCLES+RESET_HOLD. With defaults this is edge 1043.
- Loss latency: count edge 1 as the first edge sampling `locked`=0 while in RUN. After edge SYNC_STAGES+1:
  - `sys_reset`=1 and `ready`=0
  - `lost_count` and `lock_lost` are updated.
  - With defaults this is edge 3.
- Glitch rejection: a low pulse shorter than one clock period may be missed entirely; this is acceptable. Any low seen on `lock_s` during STABILIZE or HOLD_RESET restarts acquisition from WAIT_LOCK.
- `sys_reset` never deasserts while `state`≠RUN.
- `ready` == !`sys_reset` at all times.

## Test plan

All scenarios use parameters SYNC_STAGES=2, STABLE_CYCLES=8, RESET_HOLD=4, CNT_WIDTH=2.

- Reset, then `locked` held 0 for 50 cycles → `sys_reset`=1, `ready`=0, `state`=0, `lost_count`=0 throughout.
- `locked` rises and stays high → `state` passes 1 then 2, reaching 3 exactly at edge 15. `sys_reset` falls at edge 15 and not before.
- `locked` drops for 3 cycles at edge 6 of acquisition (during STABILIZE) → `state` returns to 0, `lost_count` stays 0. After `locked` returns, the full 15-edge acquisition restarts.
- In RUN, `locked` low for 5 cycles → `sys_reset`=1 at edge 3 of the drop, `lost_count`=1, `lock_lost`=1. After re-lock, `sys_reset` clears 15 edges later.
- Five separate losses from RUN → `lost_count` reads 1, 2, 3, 3, 3 (saturating). `clear_count` pulse → `lost_count`=0, `lock_lost`=0. `clear_count` coincident with a loss → `lost_count`=1.
- `reset` asserted for 1 cycle while in RUN with `lost_count`=2 → next edge: `state`=0, `sys_reset`=1, `lost_count`=0. With `locked` still high, RUN is re-reached 15 edges after `reset` drops.
